// File: rtl/mem_stage.sv
// Memory-access stage of the accumulator CPU: owns the data memory,
// performs loads/stores and registers the MEM/WB bundle.
module mem_stage #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 5,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        opcode,
   input  logic              mem_rd,
   input  logic              mem_we,
   input  logic              acc_we,
   input  logic              acc_control,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] acc_in,
   input  logic [DATA_W-1:0] alu_result,
   output logic              stall,
   output logic              acc_we_wb,
   output logic [DATA_W-1:0] wb_data,
   output logic [2:0]        opcode_wb,
   output logic [ADDR_W-1:0] addr_wb
);

   localparam int        DEPTH    = 2 ** ADDR_W;
   localparam logic      MULTI    = (READ_LAT > 1);
   localparam logic [3:0] CNT_INIT = 4'(READ_LAT - 1);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t            state, state_nxt;
   logic [3:0]        count, count_nxt;
   logic              start, done;
   logic [DATA_W-1:0] mem [DEPTH];

   logic [2:0]        l_opcode;
   logic [ADDR_W-1:0] l_addr;
   logic              l_acc_we;
   logic              l_ctl;
   logic [DATA_W-1:0] l_alu;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      start     = 1'b0;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            if (MULTI && mem_rd && !mem_we) begin
               start     = 1'b1;
               state_nxt = WAIT;
               count_nxt = CNT_INIT;
            end
         end
         WAIT: begin
            count_nxt = count - 4'd1;
            if (count == 4'd1) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign stall = (state == WAIT);

   // Write-back data reads the pre-edge memory, so a store's own
   // write-back never sees the value it is writing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_we_wb <= 1'b0;
         wb_data   <= '0;
         opcode_wb <= '0;
         addr_wb   <= '0;
         l_opcode  <= '0;
         l_addr    <= '0;
         l_acc_we  <= 1'b0;
         l_ctl     <= 1'b0;
         l_alu     <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (state == IDLE) begin
         if (mem_we) mem[addr] <= acc_in;
         if (start) begin
            l_opcode  <= opcode;
            l_addr    <= addr;
            l_acc_we  <= acc_we;
            l_ctl     <= acc_control;
            l_alu     <= alu_result;
            acc_we_wb <= 1'b0;
         end else begin
            acc_we_wb <= acc_we;
            opcode_wb <= opcode;
            addr_wb   <= addr;
            wb_data   <= acc_control ? mem[addr] : alu_result;
         end
      end else if (done) begin
         acc_we_wb <= l_acc_we;
         opcode_wb <= l_opcode;
         addr_wb   <= l_addr;
         wb_data   <= l_ctl ? mem[l_addr] : l_alu;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: three instances (READ_LAT 1, 4, 2) share one
// input bundle and are each compared against a cycle-level model.
module tb_mem_stage;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] opcode;
   logic       mem_rd, mem_we, acc_we, acc_control;
   logic [4:0] addr;
   logic [7:0] acc_in, alu_result;

   logic       st  [3];
   logic       awb [3];
   logic [7:0] wbd [3];
   logic [2:0] opw [3];
   logic [4:0] adw [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_stage #(.DATA_W(8), .ADDR_W(5), .READ_LAT(1)) u_l1 (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_rd(mem_rd),
      .mem_we(mem_we), .acc_we(acc_we), .acc_control(acc_control),
      .addr(addr), .acc_in(acc_in), .alu_result(alu_result),
      .stall(st[0]), .acc_we_wb(awb[0]), .wb_data(wbd[0]),
      .opcode_wb(opw[0]), .addr_wb(adw[0]));

   mem_stage #(.DATA_W(8), .ADDR_W(5), .READ_LAT(4)) u_l4 (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_rd(mem_rd),
      .mem_we(mem_we), .acc_we(acc_we), .acc_control(acc_control),
      .addr(addr), .acc_in(acc_in), .alu_result(alu_result),
      .stall(st[1]), .acc_we_wb(awb[1]), .wb_data(wbd[1]),
      .opcode_wb(opw[1]), .addr_wb(adw[1]));

   mem_stage #(.DATA_W(8), .ADDR_W(5), .READ_LAT(2)) u_l2 (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_rd(mem_rd),
      .mem_we(mem_we), .acc_we(acc_we), .acc_control(acc_control),
      .addr(addr), .acc_in(acc_in), .alu_result(alu_result),
      .stall(st[2]), .acc_we_wb(awb[2]), .wb_data(wbd[2]),
      .opcode_wb(opw[2]), .addr_wb(adw[2]));

   // Reference: a pending load is a stored request plus cycles remaining.
   int         lat [3] = '{1, 4, 2};
   int         busy [3];
   logic [7:0] mm [3][32];
   logic [2:0] p_op [3];
   logic [4:0] p_ad [3];
   logic       p_we [3], p_ctl [3];
   logic [7:0] p_alu [3];
   logic       e_we [3];
   logic [7:0] e_wb [3];
   logic [2:0] e_op [3];
   logic [4:0] e_ad [3];

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         busy[k] = 0;
         e_we[k] = 0; e_wb[k] = 0; e_op[k] = 0; e_ad[k] = 0;
         for (int a = 0; a < 32; a++) mm[k][a] = 8'h00;
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 3; k++) begin
         if (busy[k] > 0) begin
            busy[k]--;
            if (busy[k] == 0) begin
               e_we[k] = p_we[k];
               e_op[k] = p_op[k];
               e_ad[k] = p_ad[k];
               e_wb[k] = p_ctl[k] ? mm[k][p_ad[k]] : p_alu[k];
            end
         end else if (mem_rd && !mem_we && lat[k] > 1) begin
            p_op[k] = opcode; p_ad[k] = addr; p_we[k] = acc_we;
            p_ctl[k] = acc_control; p_alu[k] = alu_result;
            busy[k] = lat[k] - 1;
            e_we[k] = 1'b0;
         end else begin
            e_we[k] = acc_we;
            e_op[k] = opcode;
            e_ad[k] = addr;
            e_wb[k] = acc_control ? mm[k][addr] : alu_result;
            if (mem_we) mm[k][addr] = acc_in;
         end
      end
   endtask

   task automatic cmp(string tag, int k, logic [31:0] got,
                      logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s[lat%0d] got %0h exp %0h", tag, lat[k], got, exp);
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 3; k++) begin
         cmp("stall", k, 32'(st[k]), 32'(busy[k] != 0));
         cmp("acc_we_wb", k, 32'(awb[k]), 32'(e_we[k]));
         cmp("wb_data", k, 32'(wbd[k]), 32'(e_wb[k]));
         cmp("opcode_wb", k, 32'(opw[k]), 32'(e_op[k]));
         cmp("addr_wb", k, 32'(adw[k]), 32'(e_ad[k]));
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic setin(input logic [2:0] op, input logic rd,
                        input logic we, input logic aw, input logic ac,
                        input logic [4:0] a, input logic [7:0] ai,
                        input logic [7:0] alu);
      opcode = op; mem_rd = rd; mem_we = we; acc_we = aw;
      acc_control = ac; addr = a; acc_in = ai; alu_result = alu;
   endtask

   task automatic flush(input int n);
      setin(3'd0, 0, 0, 0, 0, 5'd0, 8'h00, 8'h00);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic randin(input int rd_pct, input int we_pct);
      setin(3'($urandom), ($urandom_range(99) < rd_pct),
            ($urandom_range(99) < we_pct), 1'($urandom),
            1'($urandom), 5'($urandom), 8'($urandom), 8'($urandom));
   endtask

   initial begin
      setin(3'd0, 0, 0, 0, 0, 5'd0, 8'h00, 8'h00);
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst = 1'b0;

      setin(3'b010, 0, 0, 1, 0, 5'd4, 8'h00, 8'h5A);
      tick();
      setin(3'b001, 1, 0, 1, 1, 5'd0, 8'h00, 8'hFF);
      tick();
      flush(4);

      setin(3'b011, 0, 1, 0, 0, 5'd7, 8'hC3, 8'h00);
      tick();
      setin(3'b001, 1, 0, 1, 1, 5'd7, 8'h00, 8'h00);
      tick();
      flush(4);

      setin(3'b100, 1, 1, 1, 0, 5'd31, 8'h11, 8'h22);
      tick();
      setin(3'b001, 1, 0, 1, 1, 5'd31, 8'h00, 8'h00);
      tick();
      flush(4);

      setin(3'b011, 0, 1, 0, 0, 5'd3, 8'h9E, 8'h00);
      tick();
      setin(3'b101, 1, 0, 1, 1, 5'd3, 8'h00, 8'h00);
      tick();
      for (int i = 0; i < 3; i++) begin
         randin(50, 50);
         tick();
      end
      flush(3);

      setin(3'b101, 1, 0, 1, 1, 5'd3, 8'h00, 8'h00);
      tick();
      tick();
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      rst = 1'b0;
      flush(5);
      setin(3'b001, 1, 0, 1, 1, 5'd3, 8'h00, 8'h00);
      tick();
      flush(4);

      setin(3'b011, 0, 1, 0, 0, 5'd1, 8'hA1, 8'h00);
      tick();
      setin(3'b011, 0, 1, 0, 0, 5'd2, 8'hB2, 8'h00);
      tick();
      setin(3'b110, 1, 0, 1, 1, 5'd1, 8'h00, 8'h00);
      tick();
      tick();
      setin(3'b111, 1, 0, 1, 1, 5'd2, 8'h00, 8'h00);
      tick();
      tick();
      flush(4);

      for (int i = 0; i < 400; i++) begin
         randin(40, 30);
         tick();
      end
      flush(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
